// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in / serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter width; a 2-bit word still needs one counter bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel word input channel and serial bit output channel of the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_sof;
    logic             dout_eof;

    // The environment sources words and sinks bits.
    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, dout_sof, dout_eof
    );

    // The serializer consumes words and produces bits.
    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, dout_sof, dout_eof
    );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out converter with a one-word holding buffer so that
// back-to-back words stream without a bubble.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input logic             clk,
    input logic             rst,
    piso_serializer_if.slave bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] hbuf, hbuf_nxt;
    logic             hvalid, hvalid_nxt;

    logic             in_fire;
    logic             out_fire;
    logic             last_bit;
    logic [WIDTH-1:0] sreg_shifted;

    assign in_fire      = bus.din_valid && !hvalid;
    assign out_fire     = (state == SHIFT) && bus.dout_ready;
    assign last_bit     = (cnt == LAST);
    assign sreg_shifted = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);

    assign bus.din_ready  = !hvalid;
    assign bus.dout_valid = (state == SHIFT);
    assign bus.dout       = (state == SHIFT) &&
                            ((MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0]);
    assign bus.dout_sof   = (state == SHIFT) && (cnt == '0);
    assign bus.dout_eof   = (state == SHIFT) && last_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            hbuf   <= '0;
            hvalid <= 1'b0;
        end else begin
            state  <= state_nxt;
            sreg   <= sreg_nxt;
            cnt    <= cnt_nxt;
            hbuf   <= hbuf_nxt;
            hvalid <= hvalid_nxt;
        end
    end

    // A word that is not loaded straight into sreg always lands in hbuf,
    // including one arriving while the final bit is stalled.
    always_comb begin
        state_nxt  = state;
        sreg_nxt   = sreg;
        cnt_nxt    = cnt;
        hbuf_nxt   = hbuf;
        hvalid_nxt = hvalid;

        case (state)
            IDLE: begin
                if (in_fire) begin
                    sreg_nxt  = bus.din;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (out_fire && !last_bit) begin
                    sreg_nxt = sreg_shifted;
                    cnt_nxt  = cnt + 1'b1;
                    if (in_fire) begin
                        hbuf_nxt   = bus.din;
                        hvalid_nxt = 1'b1;
                    end
                end else if (out_fire) begin
                    cnt_nxt = '0;
                    if (hvalid) begin
                        sreg_nxt   = hbuf;
                        hvalid_nxt = 1'b0;
                    end else if (in_fire) begin
                        sreg_nxt = bus.din;
                    end else begin
                        sreg_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end else if (in_fire) begin
                    hbuf_nxt   = bus.din;
                    hvalid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer at WIDTH=4, one MSB-first and one
// LSB-first instance; outputs compared as {din_ready,dout_valid,dout,sof,eof}.
module tb_piso_serializer;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    piso_serializer_if #(.WIDTH(WIDTH)) bus_msb ();
    piso_serializer_if #(.WIDTH(WIDTH)) bus_lsb ();

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_msb)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] obs_msb();
        return {bus_msb.din_ready, bus_msb.dout_valid, bus_msb.dout,
                bus_msb.dout_sof, bus_msb.dout_eof};
    endfunction

    function automatic logic [4:0] obs_lsb();
        return {bus_lsb.din_ready, bus_lsb.dout_valid, bus_lsb.dout,
                bus_lsb.dout_sof, bus_lsb.dout_eof};
    endfunction

    task automatic check_output(input string tag, input logic [4:0] observed,
                                input logic [4:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Drive inputs away from the edge, clock once, then sample.
    task automatic apply_stimulus(input bit lsb, input logic [3:0] d, input logic dv,
                                  input logic dr, input logic [4:0] expected,
                                  input string tag);
        if (lsb) begin
            bus_lsb.din        = d;
            bus_lsb.din_valid  = dv;
            bus_lsb.dout_ready = dr;
        end else begin
            bus_msb.din        = d;
            bus_msb.din_valid  = dv;
            bus_msb.dout_ready = dr;
        end
        @(posedge clk);
        #1;
        check_output(tag, lsb ? obs_lsb() : obs_msb(), expected);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        bus_msb.din = '0;  bus_msb.din_valid = 1'b0;  bus_msb.dout_ready = 1'b1;
        bus_lsb.din = '0;  bus_lsb.din_valid = 1'b0;  bus_lsb.dout_ready = 1'b1;

        @(posedge clk);
        #1;
        check_output("reset_msb", obs_msb(), 5'b10000);
        check_output("reset_lsb", obs_lsb(), 5'b10000);
        rst = 1'b1;
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b10000, "idle_msb");

        // Single word 1011, MSB first: 1,0,1,1
        apply_stimulus(0, 4'b1011, 1'b1, 1'b1, 5'b11110, "msb_b1");
        apply_stimulus(0, 4'h0,    1'b0, 1'b1, 5'b11000, "msb_b2");
        apply_stimulus(0, 4'h0,    1'b0, 1'b1, 5'b11100, "msb_b3");
        apply_stimulus(0, 4'h0,    1'b0, 1'b1, 5'b11101, "msb_b4");
        apply_stimulus(0, 4'h0,    1'b0, 1'b1, 5'b10000, "msb_idle");

        // Single word 1011, LSB first: 1,1,0,1
        apply_stimulus(1, 4'b1011, 1'b1, 1'b1, 5'b11110, "lsb_b1");
        apply_stimulus(1, 4'h0,    1'b0, 1'b1, 5'b11100, "lsb_b2");
        apply_stimulus(1, 4'h0,    1'b0, 1'b1, 5'b11000, "lsb_b3");
        apply_stimulus(1, 4'h0,    1'b0, 1'b1, 5'b11101, "lsb_b4");
        apply_stimulus(1, 4'h0,    1'b0, 1'b1, 5'b10000, "lsb_idle");

        // Streaming A,5,C: 1010 0101 1100 without a gap
        apply_stimulus(0, 4'hA, 1'b1, 1'b1, 5'b11110, "strm_01");
        apply_stimulus(0, 4'h5, 1'b1, 1'b1, 5'b01000, "strm_02");
        apply_stimulus(0, 4'hC, 1'b1, 1'b1, 5'b01100, "strm_03");
        apply_stimulus(0, 4'hC, 1'b1, 1'b1, 5'b01001, "strm_04");
        apply_stimulus(0, 4'hC, 1'b1, 1'b1, 5'b11010, "strm_05");
        apply_stimulus(0, 4'hC, 1'b1, 1'b1, 5'b01100, "strm_06");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b01000, "strm_07");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b01101, "strm_08");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11110, "strm_09");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11100, "strm_10");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11000, "strm_11");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11001, "strm_12");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b10000, "strm_idle");

        // Word 9 with a 3-cycle stall after its 2nd bit
        apply_stimulus(0, 4'h9, 1'b1, 1'b1, 5'b11110, "stall_b1");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11000, "stall_b2");
        apply_stimulus(0, 4'h0, 1'b0, 1'b0, 5'b11000, "stall_h1");
        apply_stimulus(0, 4'h0, 1'b0, 1'b0, 5'b11000, "stall_h2");
        apply_stimulus(0, 4'h0, 1'b0, 1'b0, 5'b11000, "stall_h3");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11000, "stall_b3");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11101, "stall_b4");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b10000, "stall_idle");

        // Word 3 then word 8 offered exactly on the final bit, buffer empty
        apply_stimulus(0, 4'h3, 1'b1, 1'b1, 5'b11010, "direct_01");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11000, "direct_02");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11100, "direct_03");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11101, "direct_04");
        apply_stimulus(0, 4'h8, 1'b1, 1'b1, 5'b11110, "direct_05");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11000, "direct_06");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11000, "direct_07");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11001, "direct_08");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b10000, "direct_idle");

        // Reset during the 3rd bit of F while 3 waits in the holding buffer
        apply_stimulus(0, 4'hF, 1'b1, 1'b1, 5'b11110, "rst_b1");
        apply_stimulus(0, 4'h3, 1'b1, 1'b1, 5'b01100, "rst_b2");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b01100, "rst_b3");
        #2;
        rst = 1'b0;
        #1;
        check_output("rst_async", obs_msb(), 5'b10000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b10000, "rst_idle");
        apply_stimulus(0, 4'h6, 1'b1, 1'b1, 5'b11010, "post_b1");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11100, "post_b2");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11100, "post_b3");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b11001, "post_b4");
        apply_stimulus(0, 4'h0, 1'b0, 1'b1, 5'b10000, "post_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
